// File: rtl/pipeline_if.sv
// Instruction and bus-status bundle for the pipeline scheduler.
// The "master" modport is the instruction source; the "slave" modport is the scheduler.
interface pipeline_if;
    logic [7:0] inst;
    logic       bus_busy;
    logic [7:0] bus_owner;
    logic       mult_active;
    logic       add_active;
    logic       collision;
    logic [7:0] collision_count;

    modport master (
        output inst,
        input  bus_busy, bus_owner, mult_active, add_active, collision, collision_count
    );

    modport slave (
        input  inst,
        output bus_busy, bus_owner, mult_active, add_active, collision, collision_count
    );
endinterface

// File: rtl/pipeline.sv
// Bus-slot scheduler: one-hot ops reserve the shared bus at fixed edge offsets (LD_DATA +1, LD_COEFF +2, WRITE +5); COLLISION_COUNT_EN adds a saturating collision counter.
// All outputs are registered. There is no backpressure: an op whose slot is already taken loses its bus use and raises collision.
module pipeline (
    input  logic      clk,
    input  logic      reset,
    pipeline_if.slave bus
);
    localparam int unsigned DEPTH = 5;

    typedef struct packed {
        logic       vld;
        logic [7:0] owner;
    } res_t;

    // Entry j holds the reservation for the edge (j+1) edges after the current one.
    res_t [DEPTH-1:0] tbl_q, tbl_d;
    logic             drop_d;

    logic       bus_busy_q;
    logic [7:0] bus_owner_q;
    logic       mult_s1_q, mult_active_q;
    logic       add_s1_q, add_s2_q, add_active_q;
    logic       collision_q;

    always_comb begin
        tbl_d  = '0;
        drop_d = 1'b0;
        for (int j = 0; j < DEPTH - 1; j++) begin
            tbl_d[j] = tbl_q[j+1];
        end
        // The earlier-issued reservation always wins a slot.
        if (bus.inst[1]) begin
            if (tbl_d[0].vld) begin
                drop_d = 1'b1;
            end else begin
                tbl_d[0].vld   = 1'b1;
                tbl_d[0].owner = 8'h02;
            end
        end
        if (bus.inst[2]) begin
            if (tbl_d[1].vld) begin
                drop_d = 1'b1;
            end else begin
                tbl_d[1].vld   = 1'b1;
                tbl_d[1].owner = 8'h04;
            end
        end
        if (bus.inst[5]) begin
            if (tbl_d[4].vld) begin
                drop_d = 1'b1;
            end else begin
                tbl_d[4].vld   = 1'b1;
                tbl_d[4].owner = 8'h20;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tbl_q         <= '0;
            bus_busy_q    <= 1'b0;
            bus_owner_q   <= 8'h00;
            mult_s1_q     <= 1'b0;
            mult_active_q <= 1'b0;
            add_s1_q      <= 1'b0;
            add_s2_q      <= 1'b0;
            add_active_q  <= 1'b0;
            collision_q   <= 1'b0;
        end else begin
            tbl_q         <= tbl_d;
            bus_busy_q    <= tbl_q[0].vld;
            bus_owner_q   <= tbl_q[0].owner;
            mult_s1_q     <= bus.inst[3];
            mult_active_q <= mult_s1_q;
            add_s1_q      <= bus.inst[4];
            add_s2_q      <= add_s1_q;
            add_active_q  <= add_s2_q;
            collision_q   <= drop_d;
        end
    end

    assign bus.bus_busy    = bus_busy_q;
    assign bus.bus_owner   = bus_owner_q;
    assign bus.mult_active = mult_active_q;
    assign bus.add_active  = add_active_q;
    assign bus.collision   = collision_q;

`ifdef COLLISION_COUNT_EN
    logic [7:0] coll_cnt_q, coll_cnt_d;

    // Counts alongside the collision pulse so both become visible in the same cycle.
    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (drop_d && coll_cnt_q != 8'hFF) begin
            coll_cnt_d = coll_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coll_cnt_q <= 8'h00;
        end else begin
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign bus.collision_count = coll_cnt_q;
`else
    assign bus.collision_count = 8'h00;
`endif
endmodule

// File: tb/tb_pipeline.sv
// Directed and random stimulus for the pipeline scheduler, checked against a model that
// books bus slots by absolute edge number.
module tb_pipeline;
    logic clk = 1'b0;
    logic reset;

    pipeline_if bus_if ();

    pipeline u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

`ifdef COLLISION_COUNT_EN
    localparam logic [7:0] C1_CNT  = 8'd1;
    localparam logic [7:0] SAT_CNT = 8'd255;
`else
    localparam logic [7:0] C1_CNT  = 8'd0;
    localparam logic [7:0] SAT_CNT = 8'd0;
`endif

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    // Model state: bus bookings keyed by the absolute edge that grants them.
    logic [7:0] res_m [int];
    logic [7:0] prev1 = 8'h00;
    logic [7:0] prev2 = 8'h00;
    logic       exp_busy = 1'b0;
    logic       exp_mult = 1'b0;
    logic       exp_add  = 1'b0;
    logic       exp_coll = 1'b0;
    logic [7:0] exp_owner = 8'h00;
    logic [7:0] exp_cnt   = 8'h00;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [7:0] in, input logic rst);
        logic drop;
        int   k;
        edge_n++;
        if (rst) begin
            res_m.delete();
            prev1     = 8'h00;
            prev2     = 8'h00;
            exp_busy  = 1'b0;
            exp_owner = 8'h00;
            exp_mult  = 1'b0;
            exp_add   = 1'b0;
            exp_coll  = 1'b0;
            exp_cnt   = 8'h00;
        end else begin
            exp_busy  = res_m.exists(edge_n);
            exp_owner = exp_busy ? res_m[edge_n] : 8'h00;
            if (exp_busy) res_m.delete(edge_n);
            exp_mult = prev1[3];
            exp_add  = prev2[4];
            drop = 1'b0;
            for (int b = 0; b < 8; b++) begin
                k = (b == 1) ? 1 : (b == 2) ? 2 : (b == 5) ? 5 : 0;
                if (in[b] && k != 0) begin
                    if (res_m.exists(edge_n + k)) drop = 1'b1;
                    else res_m[edge_n + k] = 8'h01 << b;
                end
            end
            exp_coll = drop;
`ifdef COLLISION_COUNT_EN
            if (drop && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`endif
            prev2 = prev1;
            prev1 = in;
        end
    endtask

    task automatic step(input logic [7:0] in, input logic rst);
        @(negedge clk);
        bus_if.inst = in;
        reset       = rst;
        @(posedge clk);
        model_edge(in, rst);
        #1;
        chk("bus_busy",        {7'd0, bus_if.bus_busy},    {7'd0, exp_busy});
        chk("bus_owner",       bus_if.bus_owner,           exp_owner);
        chk("mult_active",     {7'd0, bus_if.mult_active}, {7'd0, exp_mult});
        chk("add_active",      {7'd0, bus_if.add_active},  {7'd0, exp_add});
        chk("collision",       {7'd0, bus_if.collision},   {7'd0, exp_coll});
        chk("collision_count", bus_if.collision_count,     exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at edge=%0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        bus_if.inst = 8'h00;
        reset       = 1'b1;
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);

        // Normal sequence: no collisions expected.
        step(8'h02, 1'b0);
        step(8'h04, 1'b0);
        repeat (4) step(8'h18, 1'b0);
        step(8'h20, 1'b0);
        step(8'h01, 1'b0);
        repeat (7) step(8'h00, 1'b0);
        chk("normal_count", bus_if.collision_count, 8'd0);

        // Collide 1: LD_DATA lands on LD_COEFF's slot.
        step(8'h00, 1'b1);
        step(8'h04, 1'b0);
        step(8'h02, 1'b0);
        step(8'h18, 1'b0);
        repeat (4) step(8'h00, 1'b0);
        chk("c1_count", bus_if.collision_count, C1_CNT);

        // Collide 2: late LD_COEFF lands on WRITE's slot.
        step(8'h00, 1'b1);
        step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        step(8'h02, 1'b0);
        step(8'h18, 1'b0);
        step(8'h18, 1'b0);
        step(8'h20, 1'b0);
        step(8'h18, 1'b0);
        step(8'h18, 1'b0);
        step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        repeat (6) step(8'h00, 1'b0);
        chk("c2_count", bus_if.collision_count, C1_CNT);

        // Reset cancels a pending WRITE.
        step(8'h00, 1'b1);
        step(8'h20, 1'b0);
        step(8'h18, 1'b0);
        step(8'h00, 1'b1);
        repeat (6) step(8'h00, 1'b0);

        // Instruction presented during reset is discarded.
        step(8'h3E, 1'b1);
        repeat (6) step(8'h00, 1'b0);

        // Random instructions with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom);
            step(r, ($urandom_range(0, 39) == 0));
        end

        // Saturation: LD_DATA|LD_COEFF every cycle collides on each edge after the first.
        step(8'h00, 1'b1);
        repeat (310) step(8'h06, 1'b0);
        chk("sat_count", bus_if.collision_count, SAT_CNT);
        repeat (3) step(8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline.md
PIPELINE -- requirements
Module: pipeline

Interface
REQ-001 Parameters: none; one-hot opcode bit positions are fixed constants NOP=0, LD_DATA=1, LD_COEFF=2, MULT=3, ADD=4, WRITE=5; bits 6-7 are reserved.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 inst  input  8  one instruction per cycle, sampled every rising edge; multiple op bits may be set together (e.g. ADD|MULT).
REQ-006 bus_busy  output  1  shared memory bus granted this cycle.
REQ-007 bus_owner  output  8  one-hot opcode bit of the op owning the bus this cycle; 0 when idle.
REQ-008 mult_active  output  1  multiplier stage busy this cycle.
REQ-009 add_active  output  1  accumulator stage busy this cycle.
REQ-010 collision  output  1  one-cycle pulse: the op issued at the previous edge lost a bus slot.
REQ-011 collision_count  output  8  saturating count of collisions since reset.

Function
REQ-012 An instruction sampled at edge E0 reserves the bus at a fixed offset: LD_DATA at edge E0+1, LD_COEFF at E0+2, WRITE at E0+5.
REQ-013 Reservations are held in a 5-entry table indexed by edges-ahead; it shifts down by one entry every edge.
REQ-014 At edge E0+k, bus_owner shall be loaded with the owner of the entry due at offset k, and bus_busy with its valid bit; both are registered.
REQ-015 If a new op targets an entry already reserved, the existing (earlier-issued) reservation is kept and the new op's bus use is dropped.
REQ-016 On a drop, collision shall be 1 for exactly the cycle following E0, then return to 0.
REQ-017 Multiple drops at one edge count as one collision.
REQ-018 Ops within one inst never conflict, because their offsets differ.
REQ-019 MULT sampled at E0 drives mult_active=1 for the cycle after E0+1.
REQ-020 ADD sampled at E0 drives add_active=1 for the cycle after E0+2.
REQ-021 mult_active and add_active are not dependent on bus grants.
REQ-022 NOP, reserved bits, and inst=0 have no effect.
REQ-023 Back-to-back ADD|MULT every cycle shall keep mult_active and add_active continuously high.
REQ-024 collision_count increments by 1 per collision pulse and holds at 255.

Reset
REQ-025 While reset=1 at a rising edge, all of the following clear to 0: reservation table, bus_busy, bus_owner, mult_active, add_active, collision, collision_count.
REQ-026 inst sampled during a reset edge is discarded.
REQ-027 Reset mid-operation cancels all pending reservations; no later grant from them appears.

Configuration
REQ-028 With COLLISION_COUNT_EN defined, collision_count behaves per REQ-024.
REQ-029 Without COLLISION_COUNT_EN, collision_count is constant 0 and no counter register exists; collision is unaffected.

Verification
REQ-030 Normal sequence: LD_DATA, LD_COEFF, ADD|MULT x4, WRITE, NOP on consecutive cycles from E0.
- Bus grants: LD_DATA after E1, LD_COEFF after E3, WRITE after E11.
- mult_active high after E3..E6; add_active high after E4..E7.
- collision never asserts.
REQ-031 Collide 1: LD_COEFF at E0, LD_DATA at E1, ADD|MULT at E2.
- Both target E2; LD_COEFF owns the bus after E2; LD_DATA is dropped.
- collision=1 only in the cycle after E1; collision_count=1.
REQ-032 Collide 2: LD_COEFF, NOP, LD_DATA, ADD|MULT, ADD|MULT, WRITE, ADD|MULT, ADD|MULT, LD_COEFF, NOP.
- Grants: LD_COEFF after E2, LD_DATA after E3, WRITE after E10.
- The second LD_COEFF (E8) is dropped; collision pulse after E8; count=1.
REQ-033 Reset mid-operation: issue WRITE at E0, assert reset at E2.
- No grant after E5; all outputs are 0 after E2.
REQ-034 Saturation: 300 forced collisions -> collision_count=255.
- Without COLLISION_COUNT_EN, collision_count=0 throughout.
